// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage core: merges stall requests,
// detects load-use hazards, resolves jump redirects and sequences interrupt entry.
module pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  input  logic                   ex_inst_is_load_i,
  input  logic [RADDR_WIDTH-1:0] ex_rd_i,
  input  logic                   if_stall_req_i,
  input  logic                   ex_stall_req_i,
  input  logic                   mem_stall_req_i,
  input  logic                   jump_flag_i,
  input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
  input  logic                   int_req_i,
  input  logic [ADDR_WIDTH-1:0]  int_addr_i,
  output logic [5:0]             stall_o,
  output logic                   flush_jump_o,
  output logic                   flush_int_o,
  output logic                   int_ack_o,
  output logic                   redirect_o,
  output logic [ADDR_WIDTH-1:0]  redirect_addr_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_FRNT = 6'b000111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_int_addr;
  logic [CNT_WIDTH-1:0]    r_stall_cnt;

  logic                    w_load_use;
  logic                    w_back_busy;
  logic [5:0]              w_stall;
  logic                    w_flush_jump;
  logic                    w_flush_int;
  logic                    w_int_ack;
  logic                    w_redirect;
  logic [ADDR_WIDTH-1:0]   w_redirect_addr;

  assign w_load_use = ex_inst_is_load_i && (ex_rd_i != '0) &&
                      ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_re_i && (id_rs2_i == ex_rd_i)));
  assign w_back_busy = ex_stall_req_i | mem_stall_req_i;

  // State register and latched trap vector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_int_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && int_req_i) begin
        r_int_addr <= int_addr_i;
      end
    end
  end

  // Next state plus all combinational stall/flush/redirect outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall         = 6'b000000;
    w_flush_jump    = 1'b0;
    w_flush_int     = 1'b0;
    w_int_ack       = 1'b0;
    w_redirect      = 1'b0;
    w_redirect_addr = '0;

    if (if_stall_req_i)  w_stall = w_stall | STALL_IF;
    if (w_load_use)      w_stall = w_stall | STALL_LU;
    if (ex_stall_req_i)  w_stall = w_stall | STALL_EX;
    if (mem_stall_req_i) w_stall = w_stall | STALL_MEM;

    case (r_state)
      S_IDLE: begin
        if (int_req_i) begin
          w_state_nxt = w_back_busy ? S_DRAIN : S_FLUSH;
        end
      end
      S_DRAIN: begin
        w_stall = w_stall | STALL_FRNT;
        if (!w_back_busy) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A jump waits while EXE is held; the interrupt flush wins over a jump.
    w_flush_jump = jump_flag_i && !w_stall[3] && (r_state != S_FLUSH);
    if (w_flush_jump) begin
      w_redirect      = 1'b1;
      w_redirect_addr = jump_addr_i;
      w_stall[2:0]    = 3'b000;
    end

    if (r_state == S_FLUSH) begin
      w_stall         = 6'b000000;
      w_flush_int     = 1'b1;
      w_int_ack       = 1'b1;
      w_redirect      = 1'b1;
      w_redirect_addr = r_int_addr;
    end

    if (rst_i) begin
      w_stall         = 6'b000000;
      w_flush_jump    = 1'b0;
      w_flush_int     = 1'b0;
      w_int_ack       = 1'b0;
      w_redirect      = 1'b0;
      w_redirect_addr = '0;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall[0] && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign stall_o         = w_stall;
  assign flush_jump_o    = w_flush_jump;
  assign flush_int_o     = w_flush_int;
  assign int_ack_o       = w_int_ack;
  assign redirect_o      = w_redirect;
  assign redirect_addr_o = w_redirect_addr;
  assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_re, id_rs2_re, ex_load;
  logic        if_req, ex_req, mem_req;
  logic        jump;
  logic [31:0] jump_addr;
  logic        int_req;
  logic [31:0] int_addr;

  logic [5:0]  stall,  stall2;
  logic        fj, fi, ack, red;
  logic        fj2, fi2, ack2, red2;
  logic [31:0] raddr, raddr2;
  logic [31:0] cnt;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_re_i(id_rs1_re), .id_rs2_re_i(id_rs2_re),
    .ex_inst_is_load_i(ex_load), .ex_rd_i(ex_rd),
    .if_stall_req_i(if_req), .ex_stall_req_i(ex_req), .mem_stall_req_i(mem_req),
    .jump_flag_i(jump), .jump_addr_i(jump_addr),
    .int_req_i(int_req), .int_addr_i(int_addr),
    .stall_o(stall), .flush_jump_o(fj), .flush_int_o(fi), .int_ack_o(ack),
    .redirect_o(red), .redirect_addr_o(raddr), .stall_cnt_o(cnt)
  );

  pipe_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_re_i(id_rs1_re), .id_rs2_re_i(id_rs2_re),
    .ex_inst_is_load_i(ex_load), .ex_rd_i(ex_rd),
    .if_stall_req_i(if_req), .ex_stall_req_i(ex_req), .mem_stall_req_i(mem_req),
    .jump_flag_i(jump), .jump_addr_i(jump_addr),
    .int_req_i(int_req), .int_addr_i(int_addr),
    .stall_o(stall2), .flush_jump_o(fj2), .flush_int_o(fi2), .int_ack_o(ack2),
    .redirect_o(red2), .redirect_addr_o(raddr2), .stall_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_fj,
                         input logic e_fi, input logic e_ack, input logic e_red,
                         input logic [31:0] e_addr);
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".flush_jump"}, 32'(fj), 32'(e_fj));
    chk({tag, ".flush_int"}, 32'(fi), 32'(e_fi));
    chk({tag, ".int_ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".redirect"}, 32'(red), 32'(e_red));
    chk({tag, ".redirect_addr"}, raddr, e_addr);
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_re = 1'b0; id_rs2_re = 1'b0; ex_load = 1'b0;
    if_req = 1'b0; ex_req = 1'b0; mem_req = 1'b0;
    jump = 1'b0; jump_addr = '0; int_req = 1'b0; int_addr = '0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    // Outputs must be quiet in reset even with active requests.
    jump = 1'b1; jump_addr = 32'h0000_0100; mem_req = 1'b1;
    #2;
    chk_out("reset", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.cnt", cnt, 32'd0);

    @(negedge clk); rst = 1'b0; clr(); #1;
    chk_out("idle", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Load-use on rs2
    @(negedge clk); ex_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_re = 1'b1; #1;
    chk("loaduse.stall", 32'(stall), 32'(6'b000111));
    chk("loaduse.cnt_before", cnt, 32'd0);

    @(negedge clk); ex_rd = 5'd0; id_rs2 = 5'd0; #1;
    chk("loaduse_x0.stall", 32'(stall), 32'(6'b000000));
    chk("loaduse_x0.cnt", cnt, 32'd1);

    @(negedge clk); ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd0; id_rs1_re = 1'b0; #1;
    chk("loaduse_nore.stall", 32'(stall), 32'(6'b000000));

    // mem + if stall for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clr(); mem_req = 1'b1; if_req = 1'b1; #1;
      chk("memif.stall", 32'(stall), 32'(6'b011111));
    end
    @(negedge clk); clr(); #1;
    chk("memif.cnt", cnt, 32'd4);
    chk("memif.cnt_sat", 32'(cnt2), 32'd3);

    // Jump, no stalls
    @(negedge clk); jump = 1'b1; jump_addr = 32'h0000_0100; #1;
    chk_out("jump", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);

    // Jump overrides a front-end stall
    @(negedge clk); if_req = 1'b1; #1;
    chk_out("jump_if", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);

    // Jump held off while EXE is busy
    @(negedge clk); if_req = 1'b0; ex_req = 1'b1; #1;
    chk_out("jump_exbusy", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); ex_req = 1'b0; #1;
    chk_out("jump_release", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    chk("jump.cnt", cnt, 32'd5);

    // Interrupt with drain: IDLE accept, two DRAIN cycles, FLUSH
    @(negedge clk); clr(); int_req = 1'b1; int_addr = 32'h0000_0040; mem_req = 1'b1; #1;
    chk_out("int_accept", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); int_req = 1'b0; int_addr = 32'h0; #1;
    chk_out("drain1", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); mem_req = 1'b0; #1;
    chk_out("drain2", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); jump = 1'b1; jump_addr = 32'h0000_0200; if_req = 1'b1; #1;
    chk_out("flush", 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    @(negedge clk); clr(); #1;
    chk_out("post_flush", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("int.cnt", cnt, 32'd8);

    // Async reset mid-DRAIN; request held through reset is re-sampled afterwards
    @(negedge clk); int_req = 1'b1; int_addr = 32'h0000_0080; ex_req = 1'b1; #1;
    chk("rst_drain.accept", 32'(stall), 32'(6'b001111));
    @(negedge clk); #1;
    chk_out("rst_drain.drain", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); jump = 1'b1; jump_addr = 32'h0000_0300; #2;
    rst = 1'b1; #1;
    chk_out("rst_drain.async", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_drain.cnt", cnt, 32'd0);
    chk("rst_drain.cnt_sat", 32'(cnt2), 32'd0);
    @(negedge clk); #1;
    chk("rst_drain.held_ack", 32'(ack), 32'd0);
    rst = 1'b0; jump = 1'b0; jump_addr = '0; ex_req = 1'b0; #1;
    chk_out("rst_drain.idle", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); int_req = 1'b0; int_addr = '0; #1;
    chk_out("rst_drain.resample", 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
    @(negedge clk); #1;
    chk_out("rst_drain.done", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It drives the other end of the stall/flush interface that the inter-stage pipeline registers consume: `stall_o[5:0]`, `flush_jump_o` and `flush_int_o`. It detects load-use hazards from the id_exe outputs (`inst_is_load`, `rd`) and merges stall requests from IF, EXE and MEM. It sequences interrupt entry with a drain/flush state machine and produces the PC redirect.

Parameters:
ADDR_WIDTH, 32, instruction address width
RADDR_WIDTH, 5, register-file address width
CNT_WIDTH, 32, stall-cycle counter width

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-high
id_rs1_i  in  RADDR_WIDTH  rs1 of instruction in ID
id_rs2_i  in  RADDR_WIDTH  rs2 of instruction in ID
id_rs1_re_i  in  1  ID reads rs1
id_rs2_re_i  in  1  ID reads rs2
ex_inst_is_load_i  in  1  instruction in EXE is a load (from id_exe)
ex_rd_i  in  RADDR_WIDTH  rd of instruction in EXE (from id_exe)
if_stall_req_i  in  1  fetch waiting on bus
ex_stall_req_i  in  1  multi-cycle EXE op busy
mem_stall_req_i  in  1  data bus waiting
jump_flag_i  in  1  EXE resolved taken jump/branch
jump_addr_i  in  ADDR_WIDTH  jump target
int_req_i  in  1  interrupt request (level)
int_addr_i  in  ADDR_WIDTH  trap vector
stall_o  out  6  per-stage stall, bit n = stage n held (0 PC,1 IF,2 ID,3 EXE,4 MEM,5 WB); 1 = STOP
flush_jump_o  out  1  flush IF/ID and ID/EXE for jump
flush_int_o  out  1  flush for interrupt entry
int_ack_o  out  1  one-cycle interrupt accept pulse
redirect_o  out  1  load PC with redirect_addr_o
redirect_addr_o  out  ADDR_WIDTH  new PC
stall_cnt_o  out  CNT_WIDTH  cycles with stall_o[0]=1

Behaviour:
- Reset (`rst_i` high, async): FSM=IDLE, stall_cnt_o=0, latched int addr=0. All outputs are 0 while `rst_i` is high, including combinational ones.
- Pipeline-register contract:
  - register between stage n and n+1 holds when stall[n]=1 and stall[n+1]=1;
  - inserts a bubble when stall[n]=1 and stall[n+1]=0;
  - otherwise advances.
- Load-use hazard = ex_inst_is_load_i & ex_rd_i!=0 & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)).
- Stall requests and their `stall_o` codes:
  - if_stall_req_i -> 6'b000011
  - load-use -> 6'b000111
  - ex_stall_req_i -> 6'b001111
  - mem_stall_req_i -> 6'b011111
- `stall_o` = bitwise OR of all active codes; the result is always a contiguous low-bit mask. bit5 is always 0.
- Load-use yields exactly one bubble, because the bubble clears ex_inst_is_load_i next cycle; no extra state is kept.
- flush_jump_o = jump_flag_i & ~stall_o[3] & (FSM!=FLUSH). A jump while EXE is held waits until EXE advances.
- When flush_jump_o=1:
  - redirect_o=1, redirect_addr_o=jump_addr_i;
  - stall_o bits [2:0] forced to 0 (flush overrides front-end stalls).
- Interrupt FSM (state registered):
  - IDLE: int_req_i=1 latches int_addr_i and int_req is accepted. If ex_stall_req_i | mem_stall_req_i -> DRAIN, else -> FLUSH. int_req_i is ignored in other states.
  - DRAIN: stall_o |= 6'b000111 (front end frozen). Jumps are still honoured per the rule above. Stay while ex_stall_req_i | mem_stall_req_i; else -> FLUSH.
  - FLUSH (one cycle): flush_int_o=1, int_ack_o=1, redirect_o=1, redirect_addr_o=latched vector, stall_o=0, flush_jump_o=0 (interrupt beats a simultaneous jump) -> IDLE.
- flush_int_o, int_ack_o and redirect_o outside FLUSH/jump are 0; redirect_addr_o=0 when redirect_o=0.
- stall_cnt_o increments each cycle stall_o[0]=1 and saturates at all-ones.
- Reset mid-DRAIN or mid-FLUSH: immediate return to IDLE with no ack; the request is re-sampled after reset if still asserted.

Test Plan:
- Load x5 in EXE (ex_inst_is_load_i=1, ex_rd_i=5), ID reads rs2=5 with re=1 -> stall_o=6'b000111 for one cycle. Same with ex_rd_i=0 -> stall_o=0.
- mem_stall_req_i=1 and if_stall_req_i=1 for 3 cycles -> stall_o=6'b011111 for 3 cycles; stall_cnt_o advances by 3.
- jump_flag_i=1, jump_addr_i=32'h0000_0100, no stalls -> flush_jump_o=1, redirect_o=1, redirect_addr_o=32'h100. Repeat with ex_stall_req_i=1 -> flush_jump_o=0 until ex_stall_req_i drops.
- int_req_i=1, int_addr_i=32'h0000_0040, mem_stall_req_i=1 for 2 cycles -> DRAIN for 2 cycles (stall_o=6'b011111), then one cycle with flush_int_o=int_ack_o=redirect_o=1, redirect_addr_o=32'h40, then IDLE.
- In FLUSH cycle also jump_flag_i=1, jump_addr_i=32'h200 -> redirect_addr_o=32'h40, flush_jump_o=0.
- Assert rst_i asynchronously mid-DRAIN -> all outputs 0 immediately, stall_cnt_o=0, no int_ack_o pulse.
